// File: rtl/prior_code_decoder.sv
// Receive side of the priority-encoder link: queues 3-bit request codes in a
// small FIFO and presents the head entry as a one-hot grant with valid/ready.
module prior_code_decoder #(
   parameter int CODE_W = 3,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   in_valid_i,
   input  logic [CODE_W-1:0]      in_code_i,
   output logic                   in_ready_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [2**CODE_W-1:0]   out_onehot_o,
   output logic [CODE_W-1:0]      out_code_o,
   output logic [CNT_W-1:0]       count_o,
   output logic                   drop_err_o
);

   localparam int OUT_W = 2**CODE_W;
   localparam int PTR_W = $clog2(DEPTH);

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              drop_err_q, drop_err_d;
   logic              full, empty, push, pop;
   logic [CODE_W-1:0] head_code;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = in_valid_i && !full;
   assign pop   = !empty && out_ready_i;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_err_d = drop_err_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // Full refuses even when a pop frees a slot this cycle: no pass-through.
      if (in_valid_i && full) begin
         drop_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Storage needs no reset; count alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && push) begin
         mem_q[wr_ptr_q] <= in_code_i;
      end
   end

   assign head_code = mem_q[rd_ptr_q];

   always_comb begin
      out_code_o   = '0;
      out_onehot_o = '0;
      if (!empty) begin
         out_code_o   = head_code;
         out_onehot_o = OUT_W'(1) << head_code;
      end
   end

   assign out_valid_o = !empty;
   assign in_ready_o  = !full;
   assign count_o     = count_q;
   assign drop_err_o  = drop_err_q;

endmodule
